// File: rtl/inst_encode_writer_pkg.sv
// Shared RV32I encoding constants, instruction IDs and state/format types for the
// instruction re-encoder and IMEM writer.
package inst_encode_writer_pkg;

  localparam int unsigned INST_ID_DEPTH = 6;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned XLEN          = 32;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_BEQ     = 3'b000;
  localparam logic [2:0] FUNCT3_BNE     = 3'b001;
  localparam logic [2:0] FUNCT3_BLT     = 3'b100;
  localparam logic [2:0] FUNCT3_BGE     = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU    = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU    = 3'b111;
  localparam logic [2:0] FUNCT3_LB      = 3'b000;
  localparam logic [2:0] FUNCT3_LH      = 3'b001;
  localparam logic [2:0] FUNCT3_LW      = 3'b010;
  localparam logic [2:0] FUNCT3_LBU     = 3'b100;
  localparam logic [2:0] FUNCT3_LHU     = 3'b101;
  localparam logic [2:0] FUNCT3_SB      = 3'b000;
  localparam logic [2:0] FUNCT3_SH      = 3'b001;
  localparam logic [2:0] FUNCT3_SW      = 3'b010;
  localparam logic [2:0] FUNCT3_JALR    = 3'b000;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;
  localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;

  // Instruction IDs as emitted by the decode stage; anything above ID_SW is unknown.
  localparam logic [INST_ID_DEPTH-1:0] ID_ADDI  = 6'd0;
  localparam logic [INST_ID_DEPTH-1:0] ID_SLTI  = 6'd1;
  localparam logic [INST_ID_DEPTH-1:0] ID_SLTIU = 6'd2;
  localparam logic [INST_ID_DEPTH-1:0] ID_XORI  = 6'd3;
  localparam logic [INST_ID_DEPTH-1:0] ID_ORI   = 6'd4;
  localparam logic [INST_ID_DEPTH-1:0] ID_ANDI  = 6'd5;
  localparam logic [INST_ID_DEPTH-1:0] ID_SLLI  = 6'd6;
  localparam logic [INST_ID_DEPTH-1:0] ID_SRLI  = 6'd7;
  localparam logic [INST_ID_DEPTH-1:0] ID_SRAI  = 6'd8;
  localparam logic [INST_ID_DEPTH-1:0] ID_ADD   = 6'd9;
  localparam logic [INST_ID_DEPTH-1:0] ID_SUB   = 6'd10;
  localparam logic [INST_ID_DEPTH-1:0] ID_SLL   = 6'd11;
  localparam logic [INST_ID_DEPTH-1:0] ID_SLT   = 6'd12;
  localparam logic [INST_ID_DEPTH-1:0] ID_SLTU  = 6'd13;
  localparam logic [INST_ID_DEPTH-1:0] ID_XOR   = 6'd14;
  localparam logic [INST_ID_DEPTH-1:0] ID_SRL   = 6'd15;
  localparam logic [INST_ID_DEPTH-1:0] ID_SRA   = 6'd16;
  localparam logic [INST_ID_DEPTH-1:0] ID_OR    = 6'd17;
  localparam logic [INST_ID_DEPTH-1:0] ID_AND   = 6'd18;
  localparam logic [INST_ID_DEPTH-1:0] ID_LUI   = 6'd19;
  localparam logic [INST_ID_DEPTH-1:0] ID_AUIPC = 6'd20;
  localparam logic [INST_ID_DEPTH-1:0] ID_JAL   = 6'd21;
  localparam logic [INST_ID_DEPTH-1:0] ID_JALR  = 6'd22;
  localparam logic [INST_ID_DEPTH-1:0] ID_BEQ   = 6'd23;
  localparam logic [INST_ID_DEPTH-1:0] ID_BNE   = 6'd24;
  localparam logic [INST_ID_DEPTH-1:0] ID_BLT   = 6'd25;
  localparam logic [INST_ID_DEPTH-1:0] ID_BGE   = 6'd26;
  localparam logic [INST_ID_DEPTH-1:0] ID_BLTU  = 6'd27;
  localparam logic [INST_ID_DEPTH-1:0] ID_BGEU  = 6'd28;
  localparam logic [INST_ID_DEPTH-1:0] ID_LB    = 6'd29;
  localparam logic [INST_ID_DEPTH-1:0] ID_LH    = 6'd30;
  localparam logic [INST_ID_DEPTH-1:0] ID_LW    = 6'd31;
  localparam logic [INST_ID_DEPTH-1:0] ID_LBU   = 6'd32;
  localparam logic [INST_ID_DEPTH-1:0] ID_LHU   = 6'd33;
  localparam logic [INST_ID_DEPTH-1:0] ID_SB    = 6'd34;
  localparam logic [INST_ID_DEPTH-1:0] ID_SH    = 6'd35;
  localparam logic [INST_ID_DEPTH-1:0] ID_SW    = 6'd36;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE
  } state_e;

endpackage

// File: rtl/inst_encode_comb.sv
// Purely combinational re-encoder: decoded fields -> RV32I word plus a legality flag
// covering unknown IDs and immediates the target format cannot represent.
module inst_encode_comb
  import inst_encode_writer_pkg::*;
#(
  parameter int unsigned IDW = INST_ID_DEPTH
) (
  input  logic [IDW-1:0]  inst_id,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] word,
  output logic            legal
);

  fmt_e       fmt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       imm_i_ok;
  logic       imm_b_ok;
  logic       imm_j_ok;
  logic       imm_u_ok;

  // Format and fixed opcode fields per instruction ID.
  always_comb begin
    fmt    = FMT_BAD;
    opcode = 7'b0;
    funct3 = 3'b0;
    funct7 = FUNCT7_ZERO;
    case (inst_id)
      IDW'(ID_ADDI):  begin fmt = FMT_I;  opcode = OPCODE_OP_IMM; funct3 = FUNCT3_ADD_SUB; end
      IDW'(ID_SLTI):  begin fmt = FMT_I;  opcode = OPCODE_OP_IMM; funct3 = FUNCT3_SLT;     end
      IDW'(ID_SLTIU): begin fmt = FMT_I;  opcode = OPCODE_OP_IMM; funct3 = FUNCT3_SLTU;    end
      IDW'(ID_XORI):  begin fmt = FMT_I;  opcode = OPCODE_OP_IMM; funct3 = FUNCT3_XOR;     end
      IDW'(ID_ORI):   begin fmt = FMT_I;  opcode = OPCODE_OP_IMM; funct3 = FUNCT3_OR;      end
      IDW'(ID_ANDI):  begin fmt = FMT_I;  opcode = OPCODE_OP_IMM; funct3 = FUNCT3_AND;     end
      IDW'(ID_SLLI):  begin fmt = FMT_SH; opcode = OPCODE_OP_IMM; funct3 = FUNCT3_SLL;     end
      IDW'(ID_SRLI):  begin fmt = FMT_SH; opcode = OPCODE_OP_IMM; funct3 = FUNCT3_SRL_SRA; end
      IDW'(ID_SRAI):  begin fmt = FMT_SH; opcode = OPCODE_OP_IMM; funct3 = FUNCT3_SRL_SRA;
                            funct7 = FUNCT7_SRA; end
      IDW'(ID_ADD):   begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_ADD_SUB; end
      IDW'(ID_SUB):   begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_ADD_SUB;
                            funct7 = FUNCT7_SUB; end
      IDW'(ID_SLL):   begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_SLL;     end
      IDW'(ID_SLT):   begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_SLT;     end
      IDW'(ID_SLTU):  begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_SLTU;    end
      IDW'(ID_XOR):   begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_XOR;     end
      IDW'(ID_SRL):   begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_SRL_SRA; end
      IDW'(ID_SRA):   begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_SRL_SRA;
                            funct7 = FUNCT7_SRA; end
      IDW'(ID_OR):    begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_OR;      end
      IDW'(ID_AND):   begin fmt = FMT_R;  opcode = OPCODE_OP; funct3 = FUNCT3_AND;     end
      IDW'(ID_LUI):   begin fmt = FMT_U;  opcode = OPCODE_LUI;   end
      IDW'(ID_AUIPC): begin fmt = FMT_U;  opcode = OPCODE_AUIPC; end
      IDW'(ID_JAL):   begin fmt = FMT_J;  opcode = OPCODE_JAL;   end
      IDW'(ID_JALR):  begin fmt = FMT_I;  opcode = OPCODE_JALR; funct3 = FUNCT3_JALR; end
      IDW'(ID_BEQ):   begin fmt = FMT_B;  opcode = OPCODE_BRANCH; funct3 = FUNCT3_BEQ;  end
      IDW'(ID_BNE):   begin fmt = FMT_B;  opcode = OPCODE_BRANCH; funct3 = FUNCT3_BNE;  end
      IDW'(ID_BLT):   begin fmt = FMT_B;  opcode = OPCODE_BRANCH; funct3 = FUNCT3_BLT;  end
      IDW'(ID_BGE):   begin fmt = FMT_B;  opcode = OPCODE_BRANCH; funct3 = FUNCT3_BGE;  end
      IDW'(ID_BLTU):  begin fmt = FMT_B;  opcode = OPCODE_BRANCH; funct3 = FUNCT3_BLTU; end
      IDW'(ID_BGEU):  begin fmt = FMT_B;  opcode = OPCODE_BRANCH; funct3 = FUNCT3_BGEU; end
      IDW'(ID_LB):    begin fmt = FMT_I;  opcode = OPCODE_LOAD; funct3 = FUNCT3_LB;  end
      IDW'(ID_LH):    begin fmt = FMT_I;  opcode = OPCODE_LOAD; funct3 = FUNCT3_LH;  end
      IDW'(ID_LW):    begin fmt = FMT_I;  opcode = OPCODE_LOAD; funct3 = FUNCT3_LW;  end
      IDW'(ID_LBU):   begin fmt = FMT_I;  opcode = OPCODE_LOAD; funct3 = FUNCT3_LBU; end
      IDW'(ID_LHU):   begin fmt = FMT_I;  opcode = OPCODE_LOAD; funct3 = FUNCT3_LHU; end
      IDW'(ID_SB):    begin fmt = FMT_S;  opcode = OPCODE_STORE; funct3 = FUNCT3_SB; end
      IDW'(ID_SH):    begin fmt = FMT_S;  opcode = OPCODE_STORE; funct3 = FUNCT3_SH; end
      IDW'(ID_SW):    begin fmt = FMT_S;  opcode = OPCODE_STORE; funct3 = FUNCT3_SW; end
      default: ;
    endcase
  end

  // An immediate fits when the bits above the field are a pure sign extension.
  assign imm_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign imm_b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign imm_j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign imm_u_ok = ~(|imm[11:0]);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R:  begin word = {funct7, rs2, rs1, funct3, rd, opcode};       legal = 1'b1;     end
      FMT_I:  begin word = {imm[11:0], rs1, funct3, rd, opcode};         legal = imm_i_ok; end
      FMT_SH: begin word = {funct7, imm[4:0], rs1, funct3, rd, opcode};  legal = imm_i_ok; end
      FMT_S:  begin word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; legal = imm_i_ok; end
      FMT_B:  begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = imm_b_ok;
      end
      FMT_U:  begin word = {imm[31:12], rd, opcode}; legal = imm_u_ok; end
      FMT_J:  begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = imm_j_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encode_writer.sv
// Program loader: re-encodes decoded field bundles into RV32I words and streams
// them to instruction memory from a base address through one output register.
module inst_encode_writer
  import inst_encode_writer_pkg::*;
#(
  parameter int unsigned IDW  = INST_ID_DEPTH,
  parameter int unsigned CNTW = CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     base_addr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IDW-1:0]  in_instID,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [31:0]     in_imm,
  input  logic            in_last,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ready,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [CNTW-1:0] word_cnt,
  output logic [CNTW-1:0] err_cnt
);

  state_e          state_q;
  logic            mem_we_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic [31:0]     wr_addr_q;
  logic            err_q;
  logic [CNTW-1:0] word_cnt_q;
  logic [CNTW-1:0] err_cnt_q;

  logic            in_ready_c;
  logic            accept_c;
  logic            fire_c;
  logic [31:0]     enc_word_c;
  logic            enc_legal_c;
  logic [31:0]     wr_addr_inc_c;
  logic [31:0]     load_addr_c;
  logic            unused_c;

  inst_encode_comb #(.IDW(IDW)) u_enc (
    .inst_id (in_instID),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .rd      (in_rd),
    .imm     (in_imm),
    .word    (enc_word_c),
    .legal   (enc_legal_c)
  );

  // Output register may refill in the same cycle its current word is accepted.
  assign in_ready_c    = (state_q == ST_RUN) && (!mem_we_q || mem_ready);
  assign accept_c      = in_valid && in_ready_c;
  assign fire_c        = mem_we_q && mem_ready;
  assign wr_addr_inc_c = wr_addr_q + 32'd4;
  assign load_addr_c   = fire_c ? wr_addr_inc_c : wr_addr_q;
  assign unused_c      = ^base_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_RUN;
            wr_addr_q  <= {base_addr[31:2], 2'b00};
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (fire_c) begin
            mem_we_q   <= 1'b0;
            wr_addr_q  <= wr_addr_inc_c;
            word_cnt_q <= (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNTW'(1);
          end
          if (accept_c) begin
            if (enc_legal_c) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= load_addr_c;
              mem_wdata_q <= enc_word_c;
            end else begin
              err_q     <= 1'b1;
              err_cnt_q <= (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNTW'(1);
            end
            if (in_last) begin
              state_q <= ST_DRAIN;
            end
          end
          if ((state_q == ST_DRAIN) && (!mem_we_q || fire_c)) begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_c;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encode_writer.sv
// Directed bench for inst_encode_writer: expected writes are queued as bundles are
// driven and checked in order as the memory port accepts them.
module tb_inst_encode_writer;
  import inst_encode_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_instID;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy, done, err;
  logic [15:0] word_cnt, err_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  logic [63:0] exp_q[$];
  int          fire_log[$];

  inst_encode_writer #(.IDW(6), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_instID(in_instID),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .err(err), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted memory write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      logic [63:0] e;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_addr", mem_addr, e[63:32]);
        chk("mem_wdata", mem_wdata, e[31:0]);
      end
      fire_log.push_back(cyc);
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_start(input logic [31:0] base);
    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send(input logic [5:0] id, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1; in_instID = id; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_imm = imm; in_last = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_instID = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_last = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single ADDI, with one-cycle write latency.
    do_start(32'h0000_0100);
    chk("run_busy", 32'(busy), 32'd1);
    expect_wr(32'h100, 32'h0050_0093);
    send(ID_ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
    @(negedge clk);
    chk("lat_mem_we", 32'(mem_we), 32'd1);
    chk("lat_mem_addr", mem_addr, 32'h100);
    wait_done();
    chk("a_word_cnt", 32'(word_cnt), 32'd1);
    chk("a_err", 32'(err), 32'd0);

    // Back-to-back stream at full throughput.
    do_start(32'h0000_0100);
    fire_log.delete();
    expect_wr(32'h100, 32'h0020_81B3);
    expect_wr(32'h104, 32'h4020_81B3);
    expect_wr(32'h108, 32'h1234_52B7);
    expect_wr(32'h10C, 32'h0020_A423);
    send(ID_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(ID_SUB, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(ID_LUI, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 1'b0);
    send(ID_SW,  5'd1, 5'd2, 5'd0, 32'd8, 1'b1);
    wait_done();
    chk("b_word_cnt", 32'(word_cnt), 32'd4);
    chk("b_fire_count", 32'(fire_log.size()), 32'd4);
    if (fire_log.size() == 4) chk("b_back_to_back", 32'(fire_log[3] - fire_log[0]), 32'd3);

    // Branch and jump encodings; misaligned base bits are dropped.
    do_start(32'h0000_0303);
    expect_wr(32'h300, 32'hFE20_9EE3);
    expect_wr(32'h304, 32'h0080_00EF);
    send(ID_BNE, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0);
    send(ID_JAL, 5'd0, 5'd0, 5'd1, 32'd8, 1'b1);
    wait_done();
    chk("c_word_cnt", 32'(word_cnt), 32'd2);

    // Illegal I-immediate is swallowed without advancing the address.
    do_start(32'h0000_0100);
    expect_wr(32'h100, 32'h0050_0093);
    send(ID_ADDI, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 1'b0);
    send(ID_ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
    wait_done();
    chk("d_err", 32'(err), 32'd1);
    chk("d_err_cnt", 32'(err_cnt), 32'd1);
    chk("d_word_cnt", 32'(word_cnt), 32'd1);

    // Boundary immediates and an unknown ID carrying in_last.
    do_start(32'h0000_0400);
    chk("e_err_cleared", 32'(err), 32'd0);
    expect_wr(32'h400, 32'h7E20_AFA3);
    send(ID_BEQ, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0);
    send(ID_LUI, 5'd0, 5'd0, 5'd5, 32'h1234_5001, 1'b0);
    send(ID_JAL, 5'd0, 5'd0, 5'd1, 32'h0010_0000, 1'b0);
    send(ID_SW,  5'd1, 5'd2, 5'd0, 32'h0000_07FF, 1'b0);
    send(6'd50,  5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    wait_done();
    chk("e_err_cnt", 32'(err_cnt), 32'd4);
    chk("e_word_cnt", 32'(word_cnt), 32'd1);

    // Memory backpressure: output held stable, intake stalled.
    do_start(32'h0000_0200);
    mem_ready = 1'b0;
    expect_wr(32'h200, 32'h0050_0093);
    expect_wr(32'h204, 32'h0020_81B3);
    send(ID_ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_mem_we", 32'(mem_we), 32'd1);
      chk("stall_mem_addr", mem_addr, 32'h200);
      chk("stall_mem_wdata", mem_wdata, 32'h0050_0093);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send(ID_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    wait_done();
    chk("f_word_cnt", 32'(word_cnt), 32'd2);

    // Reset while a write is pending drops it; a fresh program starts at 0.
    do_start(32'h0000_0500);
    mem_ready = 1'b0;
    send(ID_ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0);
    @(negedge clk);
    chk("g_pending_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("g_rst_mem_we", 32'(mem_we), 32'd0);
    chk("g_rst_mem_addr", mem_addr, 32'd0);
    chk("g_rst_mem_wdata", mem_wdata, 32'd0);
    chk("g_rst_busy", 32'(busy), 32'd0);
    chk("g_rst_word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    do_start(32'h0000_0000);
    expect_wr(32'h0, 32'h0020_81B3);
    send(ID_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    wait_done();
    chk("g_word_cnt", 32'(word_cnt), 32'd1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
